sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_if.sv | 38 +++
 rtl/sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Host handshake and SRAM bus bundle for sram_ctrl.
//   master : controller side (drives SRAM pins and host status, samples req/wdata/sram_dout)
//   slave  : environment side (host plus SRAM instance)
// Host  : req, rw, addr, len, wdata -> ; <- wr_ready, rd_data, rd_valid, busy, done
// SRAM  : sram_cs, sram_oe, sram_we, sram_addr, sram_din -> ; <- sram_dout
interface sram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] len;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  done;
  logic                  sram_cs;
  logic                  sram_oe;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport master (
    input  req, rw, addr, len, wdata, sram_dout,
    output wr_ready, rd_data, rd_valid, busy, done,
    output sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );

  modport slave (
    output req, rw, addr, len, wdata, sram_dout,
    input  wr_ready, rd_data, rd_valid, busy, done,
    input  sram_cs, sram_oe, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_ctrl.sv
// Burst read/write initiator for a synchronous single-port SRAM.
// Two cycles per beat, address auto-increments modulo the memory depth.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : sram_ctrl_if.master (host handshake + SRAM pins)
// All outputs come straight from flops; control strobes are decoded from the
// next state so they change together with the state register.
module sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  sram_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_FETCH  = 3'd1,
    S_WR_STROBE = 3'd2,
    S_RD_ADDR   = 3'd3,
    S_RD_DATA   = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] beats_q, beats_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  cs_q, cs_d;
  logic                  oe_q, oe_d;
  logic                  we_q, we_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      beats_q    <= '0;
      din_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cs_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beats_q    <= beats_d;
      din_q      <= din_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cs_q       <= cs_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beats_d    = beats_q;
    din_d      = din_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cur_addr_d = bus.addr;
          beats_d    = bus.len;
          state_d    = bus.rw ? S_WR_FETCH : S_RD_ADDR;
        end
      end
      S_WR_FETCH: begin
        din_d   = bus.wdata;
        state_d = S_WR_STROBE;
      end
      S_WR_STROBE: begin
        if (beats_q != '0) begin
          beats_d    = beats_q - ADDR_WIDTH'(1);
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          state_d    = S_WR_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RD_ADDR: begin
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rd_data_d  = bus.sram_dout;
        rd_valid_d = 1'b1;
        if (beats_q != '0) begin
          beats_d    = beats_q - ADDR_WIDTH'(1);
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          state_d    = S_RD_ADDR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Leave IDLE with the write-data bus cleared
        din_d   = '0;
        beats_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore strobes for the state being entered
  always_comb begin
    cs_d       = 1'b0;
    oe_d       = 1'b0;
    we_d       = 1'b0;
    wr_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_WR_FETCH: begin
        wr_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WR_STROBE: begin
        cs_d   = 1'b1;
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_RD_ADDR: begin
        cs_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_RD_DATA: begin
        cs_d   = 1'b1;
        oe_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.sram_cs   = cs_q;
  assign bus.sram_oe   = oe_q;
  assign bus.sram_we   = we_q;
  assign bus.sram_addr = cur_addr_q;
  assign bus.sram_din  = din_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM behavioural model, cycle-indexed reference model,
// directed scenarios and a randomized phase.
module tb_sram_ctrl;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();
  sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Synchronous SRAM: write or buffer-load on the edge, output buffer when oe
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sbuf;
  always @(posedge clk or posedge reset) begin
    if (reset) sbuf <= '0;
    else if (ifc.sram_cs) begin
      if (ifc.sram_we) mem[ifc.sram_addr] <= ifc.sram_din;
      else             sbuf <= mem[ifc.sram_addr];
    end
  end
  // Distinct filler when the output is disabled so a stray sample shows up
  assign ifc.sram_dout = (ifc.sram_cs && ifc.sram_oe && !ifc.sram_we) ? sbuf : 8'hEE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: burst described by start, length and cycle index t
  bit            m_active;
  int            m_t;
  bit            m_rw;
  logic [AW-1:0] m_start, m_len, m_sram_addr;
  logic [DW-1:0] m_din, m_rd_data;
  bit            m_rdv;
  logic [DW-1:0] ref_mem [DEPTH];

  logic [DW-1:0] wtab [4];
  logic [DW-1:0] got [$];
  int            ndone;

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_t = 0; m_rdv = 0;
    m_din = '0; m_rd_data = '0; m_sram_addr = '0;
  endtask

  // Apply the effect of the clock edge that ended the previous cycle
  task automatic advance();
    int n, beat, ph;
    logic [AW-1:0] a;
    m_rdv = 0;
    if (!m_active) begin
      if (ifc.req) begin
        m_active = 1; m_t = 1; m_rw = ifc.rw;
        m_start = ifc.addr; m_len = ifc.len; m_sram_addr = ifc.addr;
      end
    end else begin
      n = 2 * (int'(m_len) + 1);
      if (m_t <= n) begin
        beat = (m_t - 1) / 2;
        ph   = (m_t - 1) % 2;
        a    = AW'(int'(m_start) + beat);
        if (m_rw && ph == 0) m_din = ifc.wdata;
        if (m_rw && ph == 1) ref_mem[a] = m_din;
        if (!m_rw && ph == 1) begin m_rdv = 1; m_rd_data = ref_mem[a]; end
        m_t++;
        if (m_t <= n) m_sram_addr = AW'(int'(m_start) + (m_t - 1) / 2);
      end else begin
        m_active = 0;
        m_din = '0;
      end
    end
  endtask

  function automatic logic [29:0] act_vec();
    return {ifc.wr_ready, ifc.rd_valid, ifc.busy, ifc.done, ifc.sram_cs, ifc.sram_oe,
            ifc.sram_we, ifc.sram_addr, ifc.sram_din, ifc.rd_data};
  endfunction

  function automatic logic [29:0] exp_vec();
    int n, ph;
    bit in_beat;
    n       = 2 * (int'(m_len) + 1);
    in_beat = m_active && (m_t <= n);
    ph      = (m_t >= 1) ? (m_t - 1) % 2 : 0;
    return {in_beat && m_rw && ph == 0, m_rdv, in_beat, m_active && (m_t == n + 1),
            in_beat && (!m_rw || ph == 1), in_beat && !m_rw && ph == 1,
            in_beat && m_rw && ph == 1, m_sram_addr, m_din, m_rd_data};
  endfunction

  task automatic compare();
    logic [29:0] a, e;
    a = act_vec();
    e = exp_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle %0d outputs {wr_ready,rd_valid,busy,done,cs,oe,we,addr,din,rd_data}: got %b expected %b",
               cyc, a, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (reset) model_reset();
    else advance();
    compare();
  endtask

  function automatic logic [DW-1:0] wval(input int mode, input logic [AW-1:0] a, input int beat);
    if (mode == 0) return (beat < 4) ? wtab[beat] : 8'h00;
    if (mode == 1) return DW'(int'(a) + beat);
    return DW'($urandom);
  endfunction

  // Issue one burst from IDLE and run it to DONE; hold keeps req high throughout
  task automatic burst(input bit r, input logic [AW-1:0] a, input logic [AW-1:0] l,
                       input int mode, input bit hold);
    int  limit;
    bit  seen;
    got.delete();
    ndone = 0;
    seen  = 0;
    ifc.req = 1'b1; ifc.rw = r; ifc.addr = a; ifc.len = l; ifc.wdata = wval(mode, a, 0);
    step();
    if (!hold) ifc.req = 1'b0;
    limit = 2 * (int'(l) + 1) + 1;
    for (int k = 1; k <= limit + 2 && !seen; k++) begin
      if (ifc.rd_valid) got.push_back(ifc.rd_data);
      if (ifc.done) begin
        ndone++;
        seen = 1;
      end else begin
        ifc.wdata = wval(mode, a, (k - 1) / 2);
        if (hold) begin
          ifc.rw = 1'($urandom); ifc.addr = AW'($urandom); ifc.len = AW'($urandom);
        end
        step();
      end
    end
    if (!seen) lit("burst_done_timeout", 32'd0, 32'd1);
    if (hold) step();
    ifc.req = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    wtab[0] = 8'h11; wtab[1] = 8'h22; wtab[2] = 8'h33; wtab[3] = 8'h44;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    reset = 1'b1;
    ifc.req = 1'b0; ifc.rw = 1'b0; ifc.addr = '0; ifc.len = '0; ifc.wdata = '0;
    step();
    step();
    lit("reset_outputs", 32'(act_vec()), 32'd0);
    reset = 1'b0;
    step();

    // Single write of 0xA5 to 0x05
    ifc.req = 1'b1; ifc.rw = 1'b1; ifc.addr = 7'h05; ifc.len = '0; ifc.wdata = 8'hA5;
    step();
    lit("wr1_wr_ready", 32'(ifc.wr_ready), 32'd1);
    ifc.req = 1'b0;
    step();
    lit("wr1_strobe", {28'd0, ifc.sram_cs, ifc.sram_we, ifc.sram_oe, 1'b0}, 32'hC);
    lit("wr1_addr", 32'(ifc.sram_addr), 32'h05);
    lit("wr1_din", 32'(ifc.sram_din), 32'hA5);
    step();
    lit("wr1_done", 32'(ifc.done), 32'd1);
    step();
    lit("wr1_mem5", 32'(mem[5]), 32'hA5);

    // Single read of 0x05
    ifc.req = 1'b1; ifc.rw = 1'b0; ifc.addr = 7'h05; ifc.len = '0;
    step();
    lit("rd1_c1_cs_oe", {30'd0, ifc.sram_cs, ifc.sram_oe}, 32'h2);
    ifc.req = 1'b0;
    step();
    lit("rd1_c2_cs_oe", {30'd0, ifc.sram_cs, ifc.sram_oe}, 32'h3);
    step();
    lit("rd1_c3_valid_done", {30'd0, ifc.rd_valid, ifc.done}, 32'h3);
    lit("rd1_data", 32'(ifc.rd_data), 32'hA5);
    step();

    // Wrapping write burst then read-back
    burst(1'b1, 7'h7E, 7'd3, 0, 1'b0);
    lit("wrap_mem7e", 32'(mem[7'h7E]), 32'h11);
    lit("wrap_mem7f", 32'(mem[7'h7F]), 32'h22);
    lit("wrap_mem00", 32'(mem[7'h00]), 32'h33);
    lit("wrap_mem01", 32'(mem[7'h01]), 32'h44);
    burst(1'b0, 7'h7E, 7'd3, 0, 1'b0);
    lit("wrap_rd_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) lit("wrap_rd_data", 32'(got[i]), 32'(wtab[i]));

    // Read burst with req held high and other inputs wandering
    burst(1'b0, 7'h7E, 7'd3, 0, 1'b1);
    lit("hold_rd_count", 32'(got.size()), 32'd4);
    lit("hold_done_count", 32'(ndone), 32'd1);

    // Reset during RD_DATA of beat 2 of 4
    ifc.req = 1'b1; ifc.rw = 1'b0; ifc.addr = 7'h7E; ifc.len = 7'd3;
    step();
    ifc.req = 1'b0;
    step();
    step();
    step();
    lit("abort_in_rd_data", {30'd0, ifc.sram_cs, ifc.sram_oe}, 32'h3);
    #2 reset = 1'b1;
    #1 lit("abort_async_zero", 32'(act_vec()), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    burst(1'b0, 7'h7F, 7'd0, 0, 1'b0);
    lit("post_abort_rd", (got.size() == 1) ? 32'(got[0]) : 32'hFFFF, 32'h22);

    // Full sweep: data = address
    burst(1'b1, 7'h00, 7'd127, 1, 1'b0);
    lit("sweep_wr_done", 32'(ndone), 32'd1);
    burst(1'b0, 7'h00, 7'd127, 1, 1'b0);
    lit("sweep_rd_count", 32'(got.size()), 32'd128);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
    lit("sweep_rd_data_bad", 32'(bad), 32'd0);
    lit("sweep_rd_done", 32'(ndone), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      ifc.req   = ($urandom_range(0, 2) == 0);
      ifc.rw    = 1'($urandom);
      ifc.addr  = AW'($urandom);
      ifc.len   = AW'($urandom_range(0, 6));
      ifc.wdata = DW'($urandom);
      step();
    end
    ifc.req = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
